// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO controller that sequences an external simple dual-port RAM, with a read latency of 1 cycle.
// Define SYNC_FIFO_CTRL_STICKY_ERR_EN to make OVERFLOW/UNDERFLOW hold until reset.
module sync_fifo_ctrl #(
  parameter int DWIDTH   = 32,
  parameter int AWIDTH   = 5,
  parameter int AF_LEVEL = (1 << AWIDTH) - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              WR_EN,
  input  logic [DWIDTH-1:0] WR_DATA,
  input  logic              RD_EN,
  output logic              RD_VALID,
  output logic              FULL,
  output logic              EMPTY,
  output logic              ALMOST_FULL,
  output logic              ALMOST_EMPTY,
  output logic [AWIDTH:0]   COUNT,
  output logic              OVERFLOW,
  output logic              UNDERFLOW,
  output logic              RAM_ENA,
  output logic              RAM_WEA,
  output logic [AWIDTH-1:0] RAM_ADDRA,
  output logic [DWIDTH-1:0] RAM_DINA,
  output logic              RAM_ENB,
  output logic [AWIDTH-1:0] RAM_ADDRB
);

  localparam logic [AWIDTH:0] AF_LVL = AF_LEVEL[AWIDTH:0];
  localparam logic [AWIDTH:0] AE_LVL = AE_LEVEL[AWIDTH:0];

  logic [AWIDTH:0] wptr;
  logic [AWIDTH:0] rptr;
  logic            wr_ok;
  logic            rd_ok;

  // Flags come from registered pointers only; the MSB disambiguates full from empty.
  assign EMPTY        = (wptr == rptr);
  assign FULL         = (wptr[AWIDTH] != rptr[AWIDTH]) &&
                        (wptr[AWIDTH-1:0] == rptr[AWIDTH-1:0]);
  assign COUNT        = wptr - rptr;
  assign ALMOST_FULL  = (COUNT >= AF_LVL);
  assign ALMOST_EMPTY = (COUNT <= AE_LVL);

  assign wr_ok = WR_EN & ~FULL & ~RST;
  assign rd_ok = RD_EN & ~EMPTY & ~RST;

  assign RAM_ENA   = wr_ok;
  assign RAM_WEA   = wr_ok;
  assign RAM_ADDRA = wptr[AWIDTH-1:0];
  assign RAM_DINA  = WR_DATA;
  assign RAM_ENB   = rd_ok;
  assign RAM_ADDRB = rptr[AWIDTH-1:0];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wptr      <= '0;
      rptr      <= '0;
      RD_VALID  <= 1'b0;
      OVERFLOW  <= 1'b0;
      UNDERFLOW <= 1'b0;
    end else begin
      if (wr_ok) wptr <= wptr + 1'b1;
      if (rd_ok) rptr <= rptr + 1'b1;
      RD_VALID <= rd_ok;
`ifdef SYNC_FIFO_CTRL_STICKY_ERR_EN
      OVERFLOW  <= OVERFLOW  | (WR_EN & FULL);
      UNDERFLOW <= UNDERFLOW | (RD_EN & EMPTY);
`else
      OVERFLOW  <= WR_EN & FULL;
      UNDERFLOW <= RD_EN & EMPTY;
`endif
    end
  end

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Bench for sync_fifo_ctrl: a queue model plus a RAM stand-in, checked every cycle, with directed literal checks.
module tb_sync_fifo_ctrl;
  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 32;
`ifdef SYNC_FIFO_CTRL_STICKY_ERR_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          WR_EN = 1'b0;
  logic [DW-1:0] WR_DATA = '0;
  logic          RD_EN = 1'b0;
  logic          RD_VALID, FULL, EMPTY, ALMOST_FULL, ALMOST_EMPTY;
  logic [AW:0]   COUNT;
  logic          OVERFLOW, UNDERFLOW, RAM_ENA, RAM_WEA, RAM_ENB;
  logic [AW-1:0] RAM_ADDRA, RAM_ADDRB;
  logic [DW-1:0] RAM_DINA;

  always #5 CLK = ~CLK;

  sync_fifo_ctrl #(.DWIDTH(DW), .AWIDTH(AW)) dut (
    .CLK(CLK), .RST(RST), .WR_EN(WR_EN), .WR_DATA(WR_DATA), .RD_EN(RD_EN),
    .RD_VALID(RD_VALID), .FULL(FULL), .EMPTY(EMPTY), .ALMOST_FULL(ALMOST_FULL),
    .ALMOST_EMPTY(ALMOST_EMPTY), .COUNT(COUNT), .OVERFLOW(OVERFLOW), .UNDERFLOW(UNDERFLOW),
    .RAM_ENA(RAM_ENA), .RAM_WEA(RAM_WEA), .RAM_ADDRA(RAM_ADDRA), .RAM_DINA(RAM_DINA),
    .RAM_ENB(RAM_ENB), .RAM_ADDRB(RAM_ADDRB)
  );

  // RAM stand-in: registered read port, so DOUTB is valid the cycle after RAM_ENB.
  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] DOUTB;
  always @(posedge CLK) begin
    if (RAM_ENA && RAM_WEA) mem[RAM_ADDRA] <= RAM_DINA;
    if (RAM_ENB) DOUTB <= mem[RAM_ADDRB];
  end

  // Reference model: contents as a queue, outputs derived from its size.
  logic [DW-1:0] q[$];
  bit            m_valid, m_ovf, m_unf;
  logic [DW-1:0] m_data;
  bit            cmp_on = 1'b0;
  int            errors = 0;
  int            checks = 0;

  function automatic void model_reset();
    q.delete();
    m_valid = 1'b0;
    m_ovf   = 1'b0;
    m_unf   = 1'b0;
  endfunction

  function automatic void model_edge();
    int n;
    n = q.size();
    if (RST) begin
      model_reset();
      return;
    end
    m_ovf   = (STICKY && m_ovf) || (WR_EN && n == DEPTH);
    m_unf   = (STICKY && m_unf) || (RD_EN && n == 0);
    m_valid = RD_EN && n > 0;
    if (m_valid) m_data = q.pop_front();
    if (WR_EN && n < DEPTH) q.push_back(WR_DATA);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge CLK) begin
    int n;
    if (cmp_on) begin
      n = q.size();
      chk("count", COUNT, n);
      chk("empty", EMPTY, n == 0);
      chk("full", FULL, n == DEPTH);
      chk("almost_full", ALMOST_FULL, n >= DEPTH - 2);
      chk("almost_empty", ALMOST_EMPTY, n <= 2);
      chk("rd_valid", RD_VALID, m_valid);
      if (m_valid) chk("doutb", DOUTB, m_data);
      chk("overflow", OVERFLOW, m_ovf);
      chk("underflow", UNDERFLOW, m_unf);
      chk("ram_ena", RAM_ENA, WR_EN && !RST && n < DEPTH);
      chk("ram_wea", RAM_WEA, WR_EN && !RST && n < DEPTH);
      chk("ram_enb", RAM_ENB, RD_EN && !RST && n > 0);
      chk("ram_dina", RAM_DINA, WR_DATA);
    end
  end

  task automatic drive(input logic w, input logic [DW-1:0] d, input logic r);
    WR_EN   = w;
    WR_DATA = d;
    RD_EN   = r;
  endtask

  task automatic tick();
    @(posedge CLK);
    model_edge();
    #1;
  endtask

  initial begin
    #1;
    chk("rst_empty", EMPTY, 1);
    chk("rst_aempty", ALMOST_EMPTY, 1);
    chk("rst_full", FULL, 0);
    chk("rst_afull", ALMOST_FULL, 0);
    chk("rst_count", COUNT, 0);
    chk("rst_valid", RD_VALID, 0);
    chk("rst_ovf", OVERFLOW, 0);
    chk("rst_unf", UNDERFLOW, 0);
    model_reset();
    cmp_on = 1'b1;
    repeat (2) tick();
    RST = 1'b0;
    repeat (3) tick();
    chk("idle_ena", RAM_ENA, 0);
    chk("idle_enb", RAM_ENB, 0);

    // Fill with 0..31, then one rejected write.
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, i, 1'b0);
      tick();
      if (i == 28) chk("af_low_at_29", ALMOST_FULL, 0);
      if (i == 29) chk("af_rise_at_30", ALMOST_FULL, 1);
    end
    chk("fill_full", FULL, 1);
    chk("fill_count", COUNT, 32);
    drive(1'b1, 32'hDEAD_BEEF, 1'b0);
    #1;
    chk("ovf_wea_blocked", RAM_WEA, 0);
    tick();
    chk("ovf_flag", OVERFLOW, 1);
    chk("ovf_count", COUNT, 32);

    // Drain in order, then one rejected read.
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b0, '0, 1'b1);
      tick();
      chk("drain_valid", RD_VALID, 1);
      chk("drain_data", DOUTB, i);
    end
    drive(1'b0, '0, 1'b0);
    #1;
    chk("drain_empty", EMPTY, 1);
    drive(1'b0, '0, 1'b1);
    tick();
    chk("unf_flag", UNDERFLOW, 1);
    chk("unf_no_valid", RD_VALID, 0);
    drive(1'b0, '0, 1'b0);
    tick();

    // Concurrent push/pop at empty and at full.
    drive(1'b1, 32'hA5A5_0001, 1'b1);
    tick();
    chk("both_empty_count", COUNT, 1);
    chk("both_empty_unf", UNDERFLOW, 1);
    for (int i = 0; i < DEPTH - 1; i++) begin
      drive(1'b1, 100 + i, 1'b0);
      tick();
    end
    chk("refill_full", FULL, 1);
    drive(1'b1, 32'hBEEF_0002, 1'b1);
    tick();
    chk("both_full_count", COUNT, 31);
    chk("both_full_ovf", OVERFLOW, 1);
    chk("both_full_valid", RD_VALID, 1);
    chk("both_full_data", DOUTB, 32'hA5A5_0001);

    // Random traffic across many pointer wraps: drain-biased then fill-biased.
    for (int i = 0; i < 1000; i++) begin
      if (i < 500) drive($urandom_range(0, 99) < 40, $urandom, $urandom_range(0, 99) < 60);
      else         drive($urandom_range(0, 99) < 60, $urandom, $urandom_range(0, 99) < 40);
      tick();
    end

    // Bring occupancy to 17, then reset asynchronously mid-cycle.
    for (int i = 0; i < 64 && q.size() != 17; i++) begin
      if (q.size() > 17) drive(1'b0, '0, 1'b1);
      else               drive(1'b1, $urandom, 1'b0);
      tick();
    end
    drive(1'b0, '0, 1'b0);
    #1;
    chk("pre_rst_count", COUNT, 17);
    chk("pre_rst_ovf", OVERFLOW, STICKY);
    @(negedge CLK);
    #2;
    RST = 1'b1;
    model_reset();
    #1;
    chk("mid_rst_empty", EMPTY, 1);
    chk("mid_rst_count", COUNT, 0);
    chk("mid_rst_full", FULL, 0);
    chk("mid_rst_aempty", ALMOST_EMPTY, 1);
    chk("mid_rst_valid", RD_VALID, 0);
    chk("mid_rst_ovf", OVERFLOW, 0);
    chk("mid_rst_unf", UNDERFLOW, 0);
    drive(1'b1, 32'h0000_0077, 1'b1);
    #1;
    chk("rst_no_ena", RAM_ENA, 0);
    chk("rst_no_enb", RAM_ENB, 0);
    tick();
    tick();
    RST = 1'b0;
    drive(1'b1, 32'h1234_5678, 1'b0);
    tick();
    drive(1'b0, '0, 1'b1);
    tick();
    chk("post_rst_valid", RD_VALID, 1);
    chk("post_rst_data", DOUTB, 32'h1234_5678);
    drive(1'b0, '0, 1'b0);
    repeat (2) tick();

    cmp_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
